// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and elaboration-time helpers
// for the timing engine.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage, W-wide enabled shift register with asynchronous reset to RST_VAL.
// N=0 degenerates to a wire.
module vga_sync_delay #(
    parameter int             N       = 1,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{clk, reset, en};
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] r_stage [N];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
                end else if (en) begin
                    r_stage[0] <= d;
                    for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign q = r_stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing engine: internal pixel tick, coordinate counters,
// latency-matched sync/blanking and registered, blanked RGB output.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_LAT = 0,
    parameter int RGB_W    = 12,
    parameter int CNT_W    = 10,
    parameter int FC_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             p_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb_out,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_IDLE  = (HS_POL == 0);
    localparam logic             VS_IDLE  = (VS_POL == 0);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_tick;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [FC_W-1:0]  r_frame_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    logic [2:0]       w_raw;
    logic [2:0]       w_dly;
    logic             r_video_on;
    logic             r_hsync;
    logic             r_vsync;
    logic [RGB_W-1:0] r_rgb;

    // The tick is registered from the next divider value so it stays low in
    // reset even when CLK_DIV=1, yet still equals (div==CLK_DIV-1) afterwards.
    always_comb begin
        w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == DIV_LAST);
        end
    end

    assign w_h_wrap = r_tick && (r_h_cnt == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_v_cnt == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (r_tick) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
            if (w_v_wrap) r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
    end

    assign w_de     = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs_act = (r_h_cnt >= H_SS) && (r_h_cnt <= H_SE);
    assign w_vs_act = (r_v_cnt >= V_SS) && (r_v_cnt <= V_SE);
    assign w_raw    = {w_de, w_hs_act, w_vs_act};

    // Matches the pixel generator latency; stages reset to "inactive".
    vga_sync_delay #(
        .N       (PIPE_LAT),
        .W       (3),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en    (r_tick),
        .d     (w_raw),
        .q     (w_dly)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_video_on <= 1'b0;
            r_hsync    <= HS_IDLE;
            r_vsync    <= VS_IDLE;
            r_rgb      <= '0;
        end else if (r_tick) begin
            r_video_on <= w_dly[2];
            r_hsync    <= w_dly[1] ^ HS_IDLE;
            r_vsync    <= w_dly[0] ^ VS_IDLE;
            r_rgb      <= w_dly[2] ? rgb_in : '0;
        end
    end

    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign p_tick      = r_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign rgb_out     = r_rgb;
    assign line_start  = w_h_wrap;
    assign frame_start = w_v_wrap;
    assign frame_count = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: three configurations (defaults, tiny CLK_DIV=1
// with active-high hsync, tiny CLK_DIV=3 with deep pipe) against a tick-count model.
module tb_vga_timing_pipe;

    typedef struct {
        int d, ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lat, fcw;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = 12'hFFF;

    cfg_t        cfg [3];
    string       iname [3] = '{"a", "b", "c"};
    logic [11:0] rgb_lat [3];
    longint      k = 0;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] o_px [3], o_py [3], o_pt [3], o_hs [3], o_vs [3];
    logic [31:0] o_von [3], o_rgb [3], o_ls [3], o_fs [3], o_fc [3];

    // ---------------- clock / reset / edge counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    // ---------------- DUTs ----------------
    logic [9:0]  a_px, a_py;
    logic [11:0] a_rgb;
    logic [7:0]  a_fc;
    logic        a_pt, a_hs, a_vs, a_von, a_ls, a_fs;

    vga_timing_pipe u_a (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(a_px), .pixel_y(a_py), .p_tick(a_pt), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .rgb_out(a_rgb), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc)
    );

    logic [3:0]  b_px, b_py;
    logic [11:0] b_rgb;
    logic [7:0]  b_fc;
    logic        b_pt, b_hs, b_vs, b_von, b_ls, b_fs;

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .PIPE_LAT(2),
        .RGB_W(12), .CNT_W(4), .FC_W(8)
    ) u_b (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(b_px), .pixel_y(b_py), .p_tick(b_pt), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .rgb_out(b_rgb), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc)
    );

    logic [4:0]  c_px, c_py;
    logic [11:0] c_rgb;
    logic [2:0]  c_fc;
    logic        c_pt, c_hs, c_vs, c_von, c_ls, c_fs;

    vga_timing_pipe #(
        .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(0), .VS_POL(1), .CLK_DIV(3), .PIPE_LAT(7),
        .RGB_W(12), .CNT_W(5), .FC_W(3)
    ) u_c (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(c_px), .pixel_y(c_py), .p_tick(c_pt), .hsync(c_hs), .vsync(c_vs),
        .video_on(c_von), .rgb_out(c_rgb), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc)
    );

    assign o_px[0] = 32'(a_px);  assign o_px[1] = 32'(b_px);  assign o_px[2] = 32'(c_px);
    assign o_py[0] = 32'(a_py);  assign o_py[1] = 32'(b_py);  assign o_py[2] = 32'(c_py);
    assign o_pt[0] = 32'(a_pt);  assign o_pt[1] = 32'(b_pt);  assign o_pt[2] = 32'(c_pt);
    assign o_hs[0] = 32'(a_hs);  assign o_hs[1] = 32'(b_hs);  assign o_hs[2] = 32'(c_hs);
    assign o_vs[0] = 32'(a_vs);  assign o_vs[1] = 32'(b_vs);  assign o_vs[2] = 32'(c_vs);
    assign o_von[0] = 32'(a_von); assign o_von[1] = 32'(b_von); assign o_von[2] = 32'(c_von);
    assign o_rgb[0] = 32'(a_rgb); assign o_rgb[1] = 32'(b_rgb); assign o_rgb[2] = 32'(c_rgb);
    assign o_ls[0] = 32'(a_ls);  assign o_ls[1] = 32'(b_ls);  assign o_ls[2] = 32'(c_ls);
    assign o_fs[0] = 32'(a_fs);  assign o_fs[1] = 32'(b_fs);  assign o_fs[2] = 32'(c_fs);
    assign o_fc[0] = 32'(a_fc);  assign o_fc[1] = 32'(b_fc);  assign o_fc[2] = 32'(c_fc);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s clk=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Model: tick number m (edges since release) fires when m%D==D-1; the
    // count of coordinates consumed and the displayed coordinate follow from it.
    function automatic bit model_tick(input int i, input longint kk);
        return (kk >= 1) && ((kk % cfg[i].d) == cfg[i].d - 1);
    endfunction

    task automatic check_inst(input int i);
        cfg_t   c;
        longint ht, vt, t, ci, h, v, hc, vc, fc;
        bit     p, ls, fs, von, hsa, vsa;
        c  = cfg[i];
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        p  = model_tick(i, k);
        t  = (c.d == 1) ? ((k >= 1) ? k - 1 : 0) : k / c.d;
        h  = t % ht;
        v  = (t / ht) % vt;
        ls = p && (h == ht - 1);
        fs = ls && (v == vt - 1);
        fc = (t / (ht * vt)) % (longint'(1) << c.fcw);
        ci = t - 1 - c.lat;
        von = 1'b0; hsa = 1'b0; vsa = 1'b0;
        if (ci >= 0) begin
            hc  = ci % ht;
            vc  = (ci / ht) % vt;
            von = (hc < c.ha) && (vc < c.va);
            hsa = (hc >= c.ha + c.hf) && (hc < c.ha + c.hf + c.hs);
            vsa = (vc >= c.va + c.vf) && (vc < c.va + c.vf + c.vs);
        end
        check({iname[i], ".pixel_x"},     o_px[i],  32'(h));
        check({iname[i], ".pixel_y"},     o_py[i],  32'(v));
        check({iname[i], ".p_tick"},      o_pt[i],  32'(p));
        check({iname[i], ".line_start"},  o_ls[i],  32'(ls));
        check({iname[i], ".frame_start"}, o_fs[i],  32'(fs));
        check({iname[i], ".frame_count"}, o_fc[i],  32'(fc));
        check({iname[i], ".video_on"},    o_von[i], 32'(von));
        check({iname[i], ".hsync"},       o_hs[i],  32'(hsa ? (c.hp != 0) : (c.hp == 0)));
        check({iname[i], ".vsync"},       o_vs[i],  32'(vsa ? (c.vp != 0) : (c.vp == 0)));
        check({iname[i], ".rgb_out"},     o_rgb[i], von ? 32'(rgb_lat[i]) : 32'd0);
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    // ---------------- driver ----------------
    // rgb_in changes every clock; the model remembers what each DUT sees at its tick.
    task automatic drive_rgb();
        rgb_in = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 3; i++) begin
            if (model_tick(i, k)) rgb_lat[i] = rgb_in;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0, 8};
        cfg[1] = '{1,   8,  2,  2,  2,   4,  1, 1,  1, 1, 0, 2, 8};
        cfg[2] = '{3,  10,  3,  4,  2,   5,  2, 3,  2, 0, 1, 7, 3};
        for (int i = 0; i < 3; i++) rgb_lat[i] = '0;

        repeat (5) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b0;

        for (int n = 0; n < 26000 && failures < 100; n++) begin
            @(negedge clk);
            check_all();
            if (n == 9000) begin
                #2 reset = 1'b1;
                #1 check_all();
                repeat (3) begin
                    @(negedge clk);
                    check_all();
                end
                reset = 1'b0;
            end
            drive_rgb();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
